// File: rtl/pmod_cls_text_sequencer.sv
// Turns a two-line, 16-character display request into Pmod CLS SPI write
// transactions (optional clear, row 0, row 1) fed to the SPI solo driver TX FIFO.
`timescale 1ns/1ps

module pmod_cls_text_sequencer #(
  parameter bit          CLEAR_ON_UPDATE = 1'b1,
  parameter int unsigned GAP_CYCLES      = 8
) (
  input  logic          i_clk_40mhz,
  input  logic          i_rst_40mhz,
  input  logic          i_update_req,
  input  logic [127:0]  i_line_top,
  input  logic [127:0]  i_line_bot,
  input  logic          i_spi_idle,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_enqueue,
  output logic [10:0]   o_tx_len,
  output logic [1:0]    o_wait_cyc,
  output logic [10:0]   o_rx_len,
  output logic          o_go_stand,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned GAP_W  = 8;

  localparam logic [1:0] SEG_CLR = 2'd0;
  localparam logic [1:0] SEG_L0  = 2'd1;
  localparam logic [1:0] SEG_L1  = 2'd2;

  localparam logic [LEN_W-1:0]  CLR_LEN  = LEN_W'(3);
  localparam logic [LEN_W-1:0]  LINE_LEN = LEN_W'(22);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BYTE_W-1:0] ESC      = 8'h1B;
  localparam logic [BYTE_W-1:0] CSI      = 8'h5B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_LOAD,
    S_L0_LOAD,
    S_L1_LOAD,
    S_GO,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          seg;
  logic [CNT_W-1:0]    byte_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                run_seen;
  logic                pending;
  logic [LINE_W-1:0]   top_q;
  logic [LINE_W-1:0]   bot_q;

  logic                start_c;
  logic                gap_end_c;
  logic                launch_c;
  logic [1:0]          launch_seg_c;

  assign o_wait_cyc = 2'b00;
  assign o_rx_len   = 11'd0;

  // Byte idx of transaction s: ESC sequence header, then characters left to right.
  function automatic logic [BYTE_W-1:0] cls_byte(input logic [1:0] s,
                                                 input logic [CNT_W-1:0] idx,
                                                 input logic [LINE_W-1:0] top,
                                                 input logic [LINE_W-1:0] bot);
    logic [LINE_W-1:0] line;
    logic [3:0]        k;
    logic [6:0]        base;
    line     = (s == SEG_L1) ? bot : top;
    k        = 4'(idx - CNT_W'(6));
    base     = {~k, 3'b000};
    cls_byte = line[base +: BYTE_W];
    if (s == SEG_CLR) begin
      case (idx)
        CNT_W'(0): cls_byte = ESC;
        CNT_W'(1): cls_byte = CSI;
        default:   cls_byte = 8'h6A;
      endcase
    end else if (idx < CNT_W'(6)) begin
      case (idx)
        CNT_W'(0): cls_byte = ESC;
        CNT_W'(1): cls_byte = CSI;
        CNT_W'(2): cls_byte = (s == SEG_L1) ? 8'h31 : 8'h30;
        CNT_W'(3): cls_byte = 8'h3B;
        CNT_W'(4): cls_byte = 8'h30;
        default:   cls_byte = 8'h48;
      endcase
    end
  endfunction

  function automatic state_t load_state(input logic [1:0] s);
    case (s)
      SEG_CLR: load_state = S_CLR_LOAD;
      SEG_L0:  load_state = S_L0_LOAD;
      default: load_state = S_L1_LOAD;
    endcase
  endfunction

  // The cycle the driver is first seen idle again counts as the first gap cycle.
  always_comb begin
    start_c      = ((state == S_IDLE) && i_update_req) ||
                   ((state == S_DONE) && (pending || i_update_req));
    gap_end_c    = ((state == S_GAP) && (gap_cnt == GAP_LAST)) ||
                   ((state == S_RUN) && run_seen && i_spi_idle && (GAP_CYCLES == 1));
    launch_seg_c = start_c ? (CLEAR_ON_UPDATE ? SEG_CLR : SEG_L0) : (seg + 2'd1);
    launch_c     = start_c || (gap_end_c && (seg != SEG_L1));
  end

  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      state        <= S_IDLE;
      seg          <= SEG_CLR;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      run_seen     <= 1'b0;
      pending      <= 1'b0;
      top_q        <= '0;
      bot_q        <= '0;
      o_tx_data    <= '0;
      o_tx_enqueue <= 1'b0;
      o_tx_len     <= '0;
      o_go_stand   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_tx_enqueue <= 1'b0;
      o_go_stand   <= 1'b0;
      o_done       <= 1'b0;

      if (i_update_req && (state != S_IDLE) && (state != S_DONE)) begin
        pending <= 1'b1;
      end

      // Lines are captured when a request is serviced, not when it arrives.
      if (start_c) begin
        top_q   <= i_line_top;
        bot_q   <= i_line_bot;
        o_busy  <= 1'b1;
        pending <= 1'b0;
      end

      if (launch_c) begin
        seg          <= launch_seg_c;
        state        <= load_state(launch_seg_c);
        o_tx_data    <= ESC;
        o_tx_enqueue <= 1'b1;
        byte_cnt     <= CNT_W'(1);
        o_tx_len     <= (launch_seg_c == SEG_CLR) ? CLR_LEN : LINE_LEN;
      end else if (gap_end_c) begin
        state  <= S_DONE;
        o_done <= 1'b1;
        o_busy <= 1'b0;
      end else begin
        case (state)
          S_CLR_LOAD, S_L0_LOAD, S_L1_LOAD: begin
            if (LEN_W'(byte_cnt) == o_tx_len) begin
              o_go_stand <= 1'b1;
              state      <= S_GO;
            end else begin
              o_tx_data    <= cls_byte(seg, byte_cnt, top_q, bot_q);
              o_tx_enqueue <= 1'b1;
              byte_cnt     <= byte_cnt + CNT_W'(1);
            end
          end
          S_GO: begin
            state    <= S_RUN;
            run_seen <= 1'b0;
          end
          // Wait for the driver to leave idle, then to return to it.
          S_RUN: begin
            if (!run_seen) begin
              if (!i_spi_idle) run_seen <= 1'b1;
            end else if (i_spi_idle) begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(1);
            end
          end
          S_GAP:  gap_cnt <= gap_cnt + GAP_W'(1);
          S_DONE: state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmod_cls_text_sequencer.sv
// Directed bench for pmod_cls_text_sequencer: byte streams, strobes, driver
// handshake timing, pending requests, mid-sequence reset and the no-clear variant.
`timescale 1ns/1ps

module tb_pmod_cls_text_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         upd;
  logic         nc_upd;
  logic [127:0] line_top;
  logic [127:0] line_bot;
  logic         spi_idle;
  logic         nc_spi_idle;

  logic [7:0]   tx_data,    nc_tx_data;
  logic         tx_enqueue, nc_tx_enqueue;
  logic [10:0]  tx_len,     nc_tx_len;
  logic [1:0]   wait_cyc,   nc_wait_cyc;
  logic [10:0]  rx_len,     nc_rx_len;
  logic         go_stand,   nc_go_stand;
  logic         busy,       nc_busy;
  logic         done,       nc_done;

  always #12.5 clk = ~clk;

  pmod_cls_text_sequencer #(.CLEAR_ON_UPDATE(1'b1), .GAP_CYCLES(8)) dut (
    .i_clk_40mhz (clk),
    .i_rst_40mhz (rst),
    .i_update_req(upd),
    .i_line_top  (line_top),
    .i_line_bot  (line_bot),
    .i_spi_idle  (spi_idle),
    .o_tx_data   (tx_data),
    .o_tx_enqueue(tx_enqueue),
    .o_tx_len    (tx_len),
    .o_wait_cyc  (wait_cyc),
    .o_rx_len    (rx_len),
    .o_go_stand  (go_stand),
    .o_busy      (busy),
    .o_done      (done)
  );

  pmod_cls_text_sequencer #(.CLEAR_ON_UPDATE(1'b0), .GAP_CYCLES(8)) dut_nc (
    .i_clk_40mhz (clk),
    .i_rst_40mhz (rst),
    .i_update_req(nc_upd),
    .i_line_top  (line_top),
    .i_line_bot  (line_bot),
    .i_spi_idle  (nc_spi_idle),
    .o_tx_data   (nc_tx_data),
    .o_tx_enqueue(nc_tx_enqueue),
    .o_tx_len    (nc_tx_len),
    .o_wait_cyc  (nc_wait_cyc),
    .o_rx_len    (nc_rx_len),
    .o_go_stand  (nc_go_stand),
    .o_busy      (nc_busy),
    .o_done      (nc_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] bytes_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         rise_q[$];
  int         len_q[$];
  int         run_q[$];
  int         done_cyc_q[$];
  bit         go_ok_q[$];
  int         go_cnt, done_cnt, run_len;
  bit         prev_enq;

  logic [7:0] nc_bytes_q[$];
  int         nc_len_q[$];
  int         nc_go_cnt, nc_done_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Record what the main instance hands to the driver.
  always @(negedge clk) begin
    if (tx_enqueue === 1'b1) begin
      bytes_q.push_back(tx_data);
      if (!prev_enq) start_q.push_back(cyc);
      run_len++;
    end
    if (go_stand === 1'b1) begin
      go_cnt++;
      go_ok_q.push_back(prev_enq && (tx_enqueue !== 1'b1));
      len_q.push_back(int'(tx_len));
      run_q.push_back(run_len);
      run_len = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    prev_enq = (tx_enqueue === 1'b1);
  end

  always @(negedge clk) begin
    if (nc_tx_enqueue === 1'b1) nc_bytes_q.push_back(nc_tx_data);
    if (nc_go_stand === 1'b1) begin
      nc_go_cnt++;
      nc_len_q.push_back(int'(nc_tx_len));
    end
    if (nc_done === 1'b1) nc_done_cnt++;
  end

  // SPI driver models: idle for a while after go, busy, then idle again.
  initial begin
    spi_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (go_stand === 1'b1) begin
        repeat (5) @(negedge clk);
        spi_idle = 1'b0;
        repeat (100) @(negedge clk);
        spi_idle = 1'b1;
        rise_q.push_back(cyc);
      end
    end
  end

  initial begin
    nc_spi_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (nc_go_stand === 1'b1) begin
        repeat (2) @(negedge clk);
        nc_spi_idle = 1'b0;
        repeat (10) @(negedge clk);
        nc_spi_idle = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req();
    upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  task automatic clear_logs();
    bytes_q.delete(); exp_q.delete(); start_q.delete(); rise_q.delete();
    len_q.delete(); run_q.delete(); done_cyc_q.delete(); go_ok_q.delete();
    go_cnt = 0; done_cnt = 0; run_len = 0; prev_enq = 1'b0;
    nc_bytes_q.delete(); nc_len_q.delete(); nc_go_cnt = 0; nc_done_cnt = 0;
  endtask

  task automatic exp_line(input logic [7:0] row, input logic [127:0] line);
    logic [7:0] b;
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(row);
    exp_q.push_back(8'h3B); exp_q.push_back(8'h30); exp_q.push_back(8'h48);
    for (int k = 0; k < 16; k++) begin
      b = line[127-8*k -: 8];
      exp_q.push_back(b);
    end
  endtask

  task automatic exp_seq(input bit clr, input logic [127:0] top, input logic [127:0] bot);
    if (clr) begin
      exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h6A);
    end
    exp_line(8'h30, top);
    exp_line(8'h31, bot);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4000 && done_cnt < target; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; upd = 1'b0; nc_upd = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({tx_data, tx_len, wait_cyc, rx_len} !== 32'd0) $display("FAIL reset_bus: got %h required 0", {tx_data, tx_len, wait_cyc, rx_len});
    else n_pass++;
    n_checks++;
    if ({tx_enqueue, go_stand} !== 2'b00) $display("FAIL reset_strobes: got enq=%b go=%b required 0", tx_enqueue, go_stand);
    else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_status: got busy=%b done=%b required 0", busy, done);
    else n_pass++;
    rst = 1'b0;
    repeat (4) step();
    n_checks++;
    if (busy !== 1'b0 || tx_enqueue !== 1'b0) $display("FAIL idle_quiet: got busy=%b enq=%b required 0", busy, tx_enqueue);
    else n_pass++;
  endtask

  task automatic test_basic();
    int errs;
    clear_logs();
    line_top = "HELLO WORLD     ";
    line_bot = "ACL2 X=+0000 mg ";
    exp_seq(1'b1, line_top, line_bot);
    pulse_req();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL accept_busy: got %b required 1", busy);
    else n_pass++;
    n_checks++;
    if (tx_enqueue !== 1'b1 || tx_data !== 8'h1B) $display("FAIL first_load: got enq=%b data=%h required enq=1 data=1b", tx_enqueue, tx_data);
    else n_pass++;
    wait_done(1);
    repeat (20) step();
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      if (bytes_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0 || bytes_q.size() != exp_q.size())
      $display("FAIL basic_stream: got %0d bytes, %0d wrong, required %0d bytes", bytes_q.size(), errs, exp_q.size());
    else n_pass++;
    n_checks++;
    if (len_q.size() != 3 || len_q[0] != 3 || len_q[1] != 22 || len_q[2] != 22)
      $display("FAIL basic_tx_len: got %p required 3,22,22", len_q);
    else n_pass++;
    n_checks++;
    if (run_q.size() != 3 || run_q[0] != 3 || run_q[1] != 22 || run_q[2] != 22)
      $display("FAIL basic_enq_runs: got %p required 3,22,22", run_q);
    else n_pass++;
    n_checks++;
    if (go_ok_q.size() != 3 || !(go_ok_q[0] && go_ok_q[1] && go_ok_q[2]))
      $display("FAIL basic_go_timing: got %0d gos, flags %p, required 3 right after last enqueue", go_ok_q.size(), go_ok_q);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses required 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_char_map();
    int errs;
    clear_logs();
    line_top = 128'h000102030405060708090A0B0C0D0E0F;
    line_bot = "0123456789ABCDEF";
    pulse_req();
    wait_done(1);
    step();
    n_checks++;
    if (bytes_q.size() != 47) $display("FAIL charmap_count: got %0d bytes required 47", bytes_q.size());
    else n_pass++;
    errs = 0;
    for (int k = 0; k < 16; k++)
      if (bytes_q.size() > 9 + k && bytes_q[9+k] !== 8'(k)) errs++;
    n_checks++;
    if (errs != 0 || bytes_q.size() < 25) $display("FAIL charmap_order: got %0d wrong chars required 0", errs);
    else n_pass++;
  endtask

  task automatic test_handshake();
    clear_logs();
    line_top = "HELLO WORLD     ";
    line_bot = "ACL2 X=+0000 mg ";
    pulse_req();
    wait_done(1);
    step();
    n_checks++;
    if (start_q.size() != 3 || rise_q.size() != 3 || done_cyc_q.size() != 1)
      $display("FAIL hs_counts: got starts=%0d rises=%0d dones=%0d required 3,3,1", start_q.size(), rise_q.size(), done_cyc_q.size());
    else n_pass++;
    if (start_q.size() == 3 && rise_q.size() == 3 && done_cyc_q.size() == 1) begin
      n_checks++;
      if (start_q[1] - rise_q[0] != 8) $display("FAIL hs_gap_l0: got %0d cycles required 8", start_q[1] - rise_q[0]);
      else n_pass++;
      n_checks++;
      if (start_q[2] - rise_q[1] != 8) $display("FAIL hs_gap_l1: got %0d cycles required 8", start_q[2] - rise_q[1]);
      else n_pass++;
      n_checks++;
      if (done_cyc_q[0] - rise_q[2] != 8) $display("FAIL hs_gap_done: got %0d cycles required 8", done_cyc_q[0] - rise_q[2]);
      else n_pass++;
    end
  endtask

  task automatic test_no_clear();
    int errs;
    int seq;
    clear_logs();
    line_top = "HELLO WORLD     ";
    line_bot = "ACL2 X=+0000 mg ";
    exp_seq(1'b0, line_top, line_bot);
    nc_upd = 1'b1;
    step();
    nc_upd = 1'b0;
    for (int i = 0; i < 2000 && nc_done_cnt < 1; i++) step();
    repeat (20) step();
    n_checks++;
    if (nc_len_q.size() != 2 || nc_len_q[0] != 22 || nc_len_q[1] != 22)
      $display("FAIL noclr_tx_len: got %p required 22,22", nc_len_q);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < nc_bytes_q.size(); i++)
      if (nc_bytes_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0 || nc_bytes_q.size() != 44)
      $display("FAIL noclr_stream: got %0d bytes, %0d wrong, required 44", nc_bytes_q.size(), errs);
    else n_pass++;
    seq = 0;
    for (int i = 0; i + 2 < nc_bytes_q.size(); i++)
      if (nc_bytes_q[i] == 8'h1B && nc_bytes_q[i+1] == 8'h5B && nc_bytes_q[i+2] == 8'h6A) seq++;
    n_checks++;
    if (seq != 0) $display("FAIL noclr_no_clear: got %0d clear sequences required 0", seq);
    else n_pass++;
    n_checks++;
    if (nc_done_cnt != 1 || nc_go_cnt != 2) $display("FAIL noclr_done: got done=%0d go=%0d required 1,2", nc_done_cnt, nc_go_cnt);
    else n_pass++;
  endtask

  task automatic test_pending();
    int errs;
    clear_logs();
    line_top = "FIRST LINE      ";
    line_bot = "FIRST BOT       ";
    exp_seq(1'b1, line_top, line_bot);
    exp_seq(1'b1, "SECOND          ", "SECOND BOTTOM   ");
    pulse_req();
    for (int i = 0; i < 2000 && go_cnt < 2; i++) step();
    repeat (3) step();
    line_top = "SECOND          ";
    line_bot = "SECOND BOTTOM   ";
    pulse_req();
    repeat (2) step();
    pulse_req();
    for (int i = 0; i < 2000 && done !== 1'b1; i++) step();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL pend_first_done: got done=%b busy=%b required 1,0", done, busy);
    else n_pass++;
    step();
    n_checks++;
    if (busy !== 1'b1 || tx_enqueue !== 1'b1) $display("FAIL pend_restart: got busy=%b enq=%b required 1,1", busy, tx_enqueue);
    else n_pass++;
    wait_done(2);
    repeat (400) step();
    n_checks++;
    if (done_cnt != 2 || go_cnt != 6) $display("FAIL pend_counts: got done=%0d go=%0d required 2,6", done_cnt, go_cnt);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      if (bytes_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0 || bytes_q.size() != 94)
      $display("FAIL pend_stream: got %0d bytes, %0d wrong, required 94", bytes_q.size(), errs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int errs;
    clear_logs();
    line_top = "HELLO WORLD     ";
    line_bot = "ACL2 X=+0000 mg ";
    pulse_req();
    for (int i = 0; i < 2000 && bytes_q.size() < 13; i++) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({tx_data, tx_len, tx_enqueue, go_stand, busy, done} !== 23'd0)
      $display("FAIL rstmid_outputs: got %h required 0", {tx_data, tx_len, tx_enqueue, go_stand, busy, done});
    else n_pass++;
    repeat (2) step();
    rst = 1'b0;
    repeat (250) step();
    n_checks++;
    if (bytes_q.size() != 13 || go_cnt != 1)
      $display("FAIL rstmid_abort: got bytes=%0d go=%0d required 13,1", bytes_q.size(), go_cnt);
    else n_pass++;
    clear_logs();
    exp_seq(1'b1, line_top, line_bot);
    pulse_req();
    wait_done(1);
    step();
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      if (bytes_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0 || bytes_q.size() != 47 || done_cnt != 1)
      $display("FAIL rstmid_restart: got %0d bytes, %0d wrong, done=%0d required 47,0,1", bytes_q.size(), errs, done_cnt);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; upd = 1'b0; nc_upd = 1'b0;
    line_top = '0; line_bot = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_char_map();
    test_handshake();
    test_no_clear();
    test_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pmod_cls_text_sequencer.md
Name: pmod_cls_text_sequencer

Overview:
- Converts a two-line, 16-character display request into Pmod CLS SPI write transactions.
- Loads the bytes into the TX FIFO of the generic stand-SPI solo driver and sequences three transactions:
  - clear display;
  - cursor row 0 plus 16 text bytes;
  - cursor row 1 plus 16 text bytes.
- Sits directly upstream of the SPI solo driver, which it feeds; it is fed by application text-formatting logic.
- Uses the shared Pmod CLS typedefs and ANSI ESC constants.

Parameters:
- CLEAR_ON_UPDATE, 1, when 1 the clear transaction (ESC [ j) precedes the line writes; when 0 it is skipped.
- GAP_CYCLES, 8, idle clock cycles inserted after each transaction completes, before the next load; range 1..255.

Ports:
- i_clk_40mhz  in  1  system clock.
- i_rst_40mhz  in  1  synchronous active-high reset.
- i_update_req  in  1  single-cycle request to redraw the display.
- i_line_top  in  128  t_pmod_cls_ascii_line_16; character k is in bits [127-8k -: 8], where k=0 is leftmost.
- i_line_bot  in  128  same layout as i_line_top, for row 1.
- i_spi_idle  in  1  SPI solo driver idle status (high = no transaction in progress).
- o_tx_data  out  8  t_pmod_cls_data_byte written to the driver TX FIFO.
- o_tx_enqueue  out  1  one-cycle write strobe for o_tx_data.
- o_tx_len  out  11  t_pmod_cls_tx_len; byte count of the current transaction.
- o_wait_cyc  out  2  t_pmod_cls_wait_cyc; always 0.
- o_rx_len  out  11  t_pmod_cls_rx_len; always 0 (the CLS is write-only).
- o_go_stand  out  1  one-cycle transaction start strobe.
- o_busy  out  1  high from request acceptance until the DONE state.
- o_done  out  1  one-cycle pulse when the whole sequence completes.

Behaviour:
- Reset:
  - All outputs are 0, state is IDLE, the pending flag is cleared, and the captured lines are cleared.
  - A reset asserted mid-sequence aborts immediately, with no further enqueue or go.
- Request acceptance:
  - In IDLE, an i_update_req seen in cycle N captures both lines and sets o_busy at N+1.
  - The first load cycle is N+1.
- Request while busy: sets a one-deep pending flag.
  - The line inputs are re-captured at the moment the pending request is serviced, not when it arrived.
  - Further requests while pending is set are merged into it.
- State sequence: IDLE -> CLR_LOAD -> GO -> RUN -> GAP -> L0_LOAD -> GO -> RUN -> GAP -> L1_LOAD -> GO -> RUN -> GAP -> DONE -> IDLE.
  - When CLEAR_ON_UPDATE=0, IDLE goes directly to L0_LOAD.
- Load states:
  - One byte is enqueued per cycle, with o_tx_enqueue high for exactly the byte count.
  - A byte counter selects each byte.
  - o_tx_len is held stable from the first enqueue until the transaction returns to idle.
- Byte sequences:
  - CLR: 1B 5B 6A, so o_tx_len=3.
  - L0: 1B 5B 30 3B 30 48 followed by the 16 top characters, so o_tx_len=22.
  - L1: 1B 5B 31 3B 30 48 followed by the 16 bottom characters, so o_tx_len=22.
- GO state: o_go_stand pulses for one cycle, in the cycle after the last enqueue.
- RUN state:
  - First waits for i_spi_idle=0, which shows the driver has started.
  - Then waits for i_spi_idle=1, which shows the transaction is complete.
  - If i_spi_idle never falls, the block waits indefinitely; no timeout.
- GAP state: a counter runs GAP_CYCLES cycles, then moves to the next load state or to DONE.
- DONE state: o_done pulses for one cycle and o_busy falls in the same cycle.
  - If pending is set, it is cleared and the next cycle behaves as an accepted request: capture, then CLR_LOAD or L0_LOAD.
  - In that case o_busy rises again at DONE+1.
- The block never asserts o_go_stand while in RUN.
- The block never enqueues outside the load states.

Test Plan:
- Basic redraw:
  - Stimulus: reset, then one i_update_req with top="HELLO WORLD     " and bot="ACL2 X=+0000 mg ".
  - Response: enqueues 3, 22 and 22 bytes, with exact byte streams as listed above.
  - Response: o_go_stand pulses three times, each one cycle after the last enqueue of its transaction.
  - Response: o_done fires once.
- CLEAR_ON_UPDATE=0: same request gives exactly two transactions of 22 bytes each and no 1B 5B 6A sequence.
- Driver handshake timing:
  - Stimulus: the bench model holds i_spi_idle high for 5 cycles after go, then low for 100 cycles.
  - Response: the next load begins exactly GAP_CYCLES=8 cycles after i_spi_idle returns high.
- Pending request:
  - Stimulus: a second request arrives during L0 RUN with new text "SECOND", followed by a third request.
  - Response: exactly one extra full sequence runs, using the "SECOND" text, and produces two o_done pulses in total.
- Reset mid-operation:
  - Stimulus: assert i_rst_40mhz during L0_LOAD after 10 enqueues.
  - Response: all outputs are 0 next cycle, with no further enqueue or go.
  - Response: a later request restarts cleanly from the CLR transaction.
- Character mapping: top line 00..0F gives L0 bytes 7..22 equal to 00,01,...,0F in order, with no byte reversal.
